// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants, state encoding and small helpers
//               for the two-requester bitwise ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Opcode encoding seen on reqN_op
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_ANDN = 2'b11;

  // Controller states; IDLE is the reset state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Round-robin helper: the requester that should be favoured next
  function automatic logic next_ptr(input logic served_id);
    return ~served_id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit
// Description : Purely combinational bitwise datapath shared by both
//               requesters (AND, OR, XOR, AND-NOT).
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Decode the opcode into one of the four bitwise functions
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ANDN: y = a & ~b;
      default: y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester front end for a shared bitwise ALU. One
//               operation is accepted at a time (round-robin on contention),
//               executed for one cycle and held on the response port until
//               the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  // response
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  state_t           state;
  logic             ptr;
  logic [1:0]       cap_op;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_id;

  logic             grant_any;
  logic             grant_id;
  logic             take;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] lu_y;

  // Pick a winner: a lone requester always wins, contention goes to ptr
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_any = 1'b1;
      grant_id  = ptr;
    end else if (req0_valid) begin
      grant_any = 1'b1;
      grant_id  = 1'b0;
    end else if (req1_valid) begin
      grant_any = 1'b1;
      grant_id  = 1'b1;
    end
  end

  // Ready only in IDLE and never while reset is held, so a transfer can
  // only ever happen from IDLE
  assign req0_ready = !rst && (state == ST_IDLE) && grant_any && !grant_id;
  assign req1_ready = !rst && (state == ST_IDLE) && grant_any &&  grant_id;
  assign take       = req0_ready | req1_ready;

  // Route the winning requester's operation toward the capture registers
  assign sel_op = grant_id ? req1_op : req0_op;
  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;

  // Single shared datapath works on the captured operands during EXEC
  logic_unit #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .op (cap_op),
    .a  (cap_a),
    .b  (cap_b),
    .y  (lu_y)
  );

  // Controller: capture in IDLE, compute in EXEC, hold the result in RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      cap_op    <= 2'b00;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            cap_op <= sel_op;
            cap_a  <= sel_a;
            cap_b  <= sel_b;
            cap_id <= grant_id;
            busy   <= 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= lu_y;
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          // The pointer only moves once the response has really left
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= next_ptr(cap_id);
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Scoreboard bench for alu_arbiter. A transaction-level model
//               decides grants and timing; expected responses are queued at
//               issue time and checked by an independent output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [1:0]       req0_op = 2'b00;
  logic [WIDTH-1:0] req0_a = '0;
  logic [WIDTH-1:0] req0_b = '0;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [1:0]       req1_op = 2'b00;
  logic [WIDTH-1:0] req1_a = '0;
  logic [WIDTH-1:0] req1_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Transaction-level model: one operation in flight, response is
  // available from the second edge after issue, pointer moves on delivery
  bit m_busy   = 1'b0;
  int m_cnt    = 0;
  bit m_ptr    = 1'b0;
  bit m_id     = 1'b0;
  bit served0  = 1'b0;
  bit served1  = 1'b0;

  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at it
  task automatic model_edge();
    exp_t e;
    bit   id;
    served0 = 1'b0;
    served1 = 1'b0;
    if (rst) return;
    if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        id     = (req0_valid && req1_valid) ? m_ptr : req1_valid;
        e.id   = id;
        e.data = id ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
        exp_q.push_back(e);
        m_busy = 1'b1;
        m_cnt  = 0;
        m_id   = id;
        if (id) served1 = 1'b1;
        else    served0 = 1'b1;
      end
    end else begin
      m_cnt++;
      if (m_cnt >= 2 && rsp_ready) begin
        m_busy = 1'b0;
        m_ptr  = !m_id;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    m_busy = 1'b0;
    m_cnt  = 0;
    m_ptr  = 1'b0;
    #1;
    check("rst_rsp_valid",  rsp_valid,  0);
    check("rst_busy",       busy,       0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp_data",   rsp_data,   0);
    check("rst_rsp_id",     rsp_id,     0);
    step();
    step();
    rst = 1'b0;
  endtask

  // Handshake/status checker against the model, away from the active edge
  always @(negedge clk) begin
    logic e0, e1;
    e0 = !rst && !m_busy && req0_valid && (!req1_valid || !m_ptr);
    e1 = !rst && !m_busy && req1_valid && (!req0_valid ||  m_ptr);
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("busy",       busy,       m_busy);
    check("rsp_valid",  rsp_valid,  m_busy && (m_cnt >= 1));
  end

  // Output monitor: every presented response must match the queue head
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d data %h expected no response", rsp_id, rsp_data);
      end else begin
        check("rsp_data", rsp_data, exp_q[0].data);
        check("rsp_id",   rsp_id,   exp_q[0].id);
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [WIDTH-1:0] sweep_exp [4];

  initial begin
    sweep_exp[0] = 32'h0A0A0505;
    sweep_exp[1] = 32'hAFAF5F5F;
    sweep_exp[2] = 32'hA5A55A5A;
    sweep_exp[3] = 32'hA0A05050;

    do_reset();

    // Contention from reset: grants 0,1,0,1 every third cycle
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = $urandom; req1_b = $urandom;
    rsp_ready  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c % 3 == 0) begin
        check("contention_r0", req0_ready, ((c / 3) % 2) == 0);
        check("contention_r1", req1_ready, ((c / 3) % 2) == 1);
      end else begin
        check("contention_idle", {req0_ready, req1_ready}, 0);
      end
      step();
      if (served0) begin req0_a = $urandom; req0_b = $urandom; end
      if (served1) begin req1_a = $urandom; req1_b = $urandom; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) step();

    // Single request with known operands
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00;
    step();
    req0_valid = 1'b0;
    step();
    check("single_valid", rsp_valid, 1);
    check("single_data",  rsp_data,  32'hF000F000);
    check("single_id",    rsp_id,    0);
    step();

    // Opcode sweep on requester 1
    for (int op = 0; op < 4; op++) begin
      req1_valid = 1'b1; req1_op = op[1:0]; req1_a = 32'hAAAA5555; req1_b = 32'h0F0F0F0F;
      step();
      req1_valid = 1'b0;
      step();
      check("sweep_data", rsp_data, sweep_exp[op]);
      check("sweep_id",   rsp_id,   1);
      step();
    end
    repeat (2) step();

    // Backpressure: response held for five cycles
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'h12345678; req0_b = 32'h0000FFFF;
    step();
    req0_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data",  rsp_data,  32'h1234A987);
      check("bp_id",    rsp_id,    0);
      check("bp_ready", {req0_ready, req1_ready}, 0);
      check("bp_busy",  busy, 1);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_release_busy",  busy,      0);
    check("bp_release_valid", rsp_valid, 0);

    // Withdrawn request: req1 pulses valid during RESP only
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b11; req0_a = $urandom; req0_b = $urandom;
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = $urandom; req1_b = $urandom;
    step();
    req1_valid = 1'b0;
    step();
    rsp_ready = 1'b1;
    step();
    repeat (2) begin
      check("withdraw_idle", busy, 0);
      step();
    end
    // req0 was served last, so contention must go to req1
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("withdraw_ptr_r1", req1_ready, 1);
    check("withdraw_ptr_r0", req0_ready, 0);
    step();
    req1_valid = 1'b0;
    step();
    req0_valid = 1'b0;
    repeat (2) step();
    // Last served was req1, now serve req0 alone so the pointer rests on 1
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    repeat (3) step();

    // Reset while in EXEC discards the operation and clears the pointer
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = $urandom; req0_b = $urandom;
    step();
    req1_valid = 1'b1;
    do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) begin
      check("post_reset_no_rsp", rsp_valid, 0);
      step();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("post_reset_ptr_r0", req0_ready, 1);
    check("post_reset_ptr_r1", req1_ready, 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) step();

    // Randomized traffic honouring the hold-until-transfer rule
    for (int i = 0; i < 800; i++) begin
      step();
      if (served0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 99) < 55);
        req0_op = 2'($urandom_range(0, 3)); req0_a = $urandom; req0_b = $urandom;
      end
      if (served1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 99) < 55);
        req1_op = 2'($urandom_range(0, 3)); req1_a = $urandom; req1_b = $urandom;
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
    end

    // Drain everything still in flight
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (6) step();
    check("drain_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
